// File: rtl/pixel_stream_source_pkg.sv
// Shared constants for the pixel stream source: FSM encoding and default image geometry.
package pixel_stream_source_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;

  localparam int unsigned DEF_IMG_WIDTH  = 320;
  localparam int unsigned DEF_IMG_HEIGHT = 240;
  localparam int unsigned DEF_PIX_BITS   = 12;
  localparam int unsigned DEF_COL_BITS   = 9;
  localparam int unsigned DEF_ROW_BITS   = 8;

  // Output buffer must absorb every read still in the ROM pipe plus one stalled head.
  function automatic int unsigned fifo_depth(input int unsigned rom_latency);
    return rom_latency + 2;
  endfunction

endpackage

// File: rtl/pix_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; push and pop may coincide.
module pix_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Raster-order ROM scanner delivering tagged pixels over valid/ready, single-shot or continuous.
module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int unsigned PIX_BITS    = DEF_PIX_BITS,
  parameter int unsigned COL_BITS    = DEF_COL_BITS,
  parameter int unsigned ROW_BITS    = DEF_ROW_BITS,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                start,
  input  logic                continuous,
  output logic                rom_en,
  output logic [ROW_BITS-1:0] rom_pix_row,
  output logic [COL_BITS-1:0] rom_pix_col,
  input  logic [PIX_BITS-1:0] rom_pixel,
  output logic [PIX_BITS-1:0] pixel_out,
  output logic [ROW_BITS-1:0] pix_row,
  output logic [COL_BITS-1:0] pix_col,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                sof,
  output logic                eol,
  output logic                eof,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned FIFO_DEPTH = fifo_depth(ROM_LATENCY);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W      = CNT_W + 1;
  localparam int unsigned TAG_W      = ROW_BITS + COL_BITS + 3;
  localparam int unsigned PAY_W      = PIX_BITS + TAG_W;
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);

  typedef logic [OCC_W-1:0] occ_t;

  state_t              state_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic                pipe_v   [ROM_LATENCY];
  logic [TAG_W-1:0]    pipe_tag [ROM_LATENCY];
  logic [CNT_W-1:0]    inflight, fifo_count;
  logic                last_addr, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PAY_W-1:0]    fifo_wdata, fifo_rdata;
  logic                frame_done_q;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LATENCY; i++) inflight = inflight + CNT_W'(pipe_v[i]);
  end

  // Credit check: every issued read already owns a FIFO slot, so backpressure never drops data.
  assign rom_en    = (state_q == ST_STREAM) &&
                     ((occ_t'(fifo_count) + occ_t'(inflight)) < occ_t'(FIFO_DEPTH));
  assign last_addr = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign rom_pix_row = row_q;
  assign rom_pix_col = col_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_q <= ST_STREAM;
        ST_STREAM: if (rom_en && last_addr && !continuous) state_q <= ST_DRAIN;
        ST_DRAIN:  if (fifo_pop && eof) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (rom_en) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= rom_en;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge Clock) begin
    pipe_tag[0] <= {row_q, col_q, (row_q == '0) && (col_q == '0), col_q == COL_LAST, last_addr};
    for (int unsigned i = 1; i < ROM_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  assign fifo_push  = pipe_v[ROM_LATENCY-1];
  assign fifo_wdata = {rom_pixel, pipe_tag[ROM_LATENCY-1]};
  assign fifo_pop   = !fifo_empty && pix_ready;

  pix_sync_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push    (fifo_push),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

  assign {pixel_out, pix_row, pix_col, sof, eol, eof} = fifo_empty ? '0 : fifo_rdata;
  assign pix_valid = !fifo_empty;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) frame_done_q <= 1'b0;
    else       frame_done_q <= fifo_pop && eof;
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Randomised bench for pixel_stream_source against a raster-order stream model.
module tb_pixel_stream_source;

  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        Reset, start, continuous, pix_ready;
  logic        rom_en, pix_valid, sof, eol, eof, busy, frame_done;
  logic [1:0]  rom_pix_row, rom_pix_col, pix_row, pix_col;
  logic [11:0] rom_pixel, pixel_out;
  logic [11:0] rp [L];

  int vectors = 0, miscompares = 0;
  int k_pop = 0, k_iss = 0, fd_cnt = 0, sof_cnt = 0;
  logic exp_fd = 1'b0, stalled_prev = 1'b0, rand_ready = 1'b0;
  logic [11:0] last_pix = '0;

  always #5 clk = ~clk;

  pixel_stream_source #(
    .IMG_WIDTH (W), .IMG_HEIGHT (H), .PIX_BITS (12),
    .COL_BITS (2), .ROW_BITS (2), .ROM_LATENCY (L)
  ) dut (
    .Clock (clk), .Reset (Reset), .start (start), .continuous (continuous),
    .rom_en (rom_en), .rom_pix_row (rom_pix_row), .rom_pix_col (rom_pix_col),
    .rom_pixel (rom_pixel), .pixel_out (pixel_out), .pix_row (pix_row),
    .pix_col (pix_col), .pix_valid (pix_valid), .pix_ready (pix_ready),
    .sof (sof), .eol (eol), .eof (eof), .busy (busy), .frame_done (frame_done)
  );

  // ROM model: data for the address presented in cycle t is visible in cycle t+L.
  always @(posedge clk) begin
    rp[0] <= 12'(rom_pix_row) * 12'd16 + 12'(rom_pix_col);
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign rom_pixel = rp[L-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream model: the k-th accepted pixel since reset is raster position k mod N.
  task automatic cycle_check();
    int p;
    if (Reset) begin
      k_pop = 0; k_iss = 0; exp_fd = 1'b0; stalled_prev = 1'b0;
      return;
    end
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (stalled_prev) chk("hold_valid", 32'(pix_valid), 1);
    if (pix_valid) begin
      p = k_pop % N;
      chk("pixel", 32'(pixel_out), (p / W) * 16 + p % W);
      chk("pix_row", 32'(pix_row), p / W);
      chk("pix_col", 32'(pix_col), p % W);
      chk("sof", 32'(sof), 32'(p == 0));
      chk("eol", 32'(eol), 32'(p % W == W - 1));
      chk("eof", 32'(eof), 32'(p == N - 1));
    end else begin
      chk("idle_fields", 32'({pixel_out, pix_row, pix_col, sof, eol, eof}), 0);
    end
    if (rom_en) begin
      p = k_iss % N;
      chk("credit", 32'((k_iss - k_pop) < L + 2), 1);
      chk("rom_row", 32'(rom_pix_row), p / W);
      chk("rom_col", 32'(rom_pix_col), p % W);
      k_iss++;
    end
    exp_fd = pix_valid && pix_ready && (k_pop % N == N - 1);
    if (pix_valid && pix_ready) begin
      if (sof) sof_cnt++;
      last_pix = pixel_out;
      k_pop++;
    end
    stalled_prev = pix_valid && !pix_ready;
    if (frame_done) fd_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || pix_valid) && n < bound) begin tick(); n++; end
    chk("idle_timeout", 32'(n < bound), 1);
    tick(); tick();
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!pix_valid && n < bound) begin tick(); n++; end
    chk("valid_timeout", 32'(n < bound), 1);
  endtask

  initial begin
    int bp, bi, bf, bs, n, gaps;
    Reset = 1'b1; start = 1'b0; continuous = 1'b0; pix_ready = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rom", 32'({rom_en, rom_pix_row, rom_pix_col}), 0);
    chk("rst_fd", 32'(frame_done), 0);

    // Single frame, always ready
    bp = k_pop; bf = fd_cnt;
    pulse_start();
    wait_valid(20, n);
    chk("first_latency", n, 3);
    chk("first_pix", 32'(pixel_out), 0);
    chk("first_sof", 32'(sof), 1);
    wait_idle(100);
    chk("t1_count", k_pop - bp, 12);
    chk("t1_last", 32'(last_pix), 32'h023);
    chk("t1_fd", fd_cnt - bf, 1);
    chk("t1_busy", 32'(busy), 0);

    // Random backpressure
    bp = k_pop; bf = fd_cnt; bi = k_iss;
    rand_ready = 1'b1;
    pulse_start();
    wait_idle(400);
    rand_ready = 1'b0; pix_ready = 1'b1;
    chk("t2_count", k_pop - bp, 12);
    chk("t2_issue", k_iss - bi, 12);
    chk("t2_last", 32'(last_pix), 32'h023);
    chk("t2_fd", fd_cnt - bf, 1);

    // Continuous for three frames, dropped during the third
    bp = k_pop; bf = fd_cnt; bi = k_iss; bs = sof_cnt; gaps = 0;
    continuous = 1'b1;
    pulse_start();
    wait_valid(20, n);
    n = 0;
    while (k_pop - bp < 36 && n < 300) begin
      if (!pix_valid) gaps++;
      if (k_iss - bi >= 26) continuous = 1'b0;
      tick(); n++;
    end
    wait_idle(100);
    chk("t3_count", k_pop - bp, 36);
    chk("t3_issue", k_iss - bi, 36);
    chk("t3_gaps", gaps, 0);
    chk("t3_fd", fd_cnt - bf, 3);
    chk("t3_sof", sof_cnt - bs, 3);

    // Continuous dropped in frame 2
    bp = k_pop; bf = fd_cnt; bi = k_iss;
    continuous = 1'b1;
    pulse_start();
    n = 0;
    while (n < 300) begin
      if (k_iss - bi >= 14) continuous = 1'b0;
      tick(); n++;
      if (n > 2 && !busy && !pix_valid) break;
    end
    repeat (10) tick();
    chk("t4_count", k_pop - bp, 24);
    chk("t4_issue", k_iss - bi, 24);
    chk("t4_fd", fd_cnt - bf, 2);
    chk("t4_busy", 32'(busy), 0);

    // Start while busy is ignored
    bp = k_pop; bf = fd_cnt; bi = k_iss;
    pulse_start();
    repeat (3) tick();
    chk("t5_busy", 32'(busy), 1);
    pulse_start();
    wait_idle(100);
    repeat (10) tick();
    chk("t5_count", k_pop - bp, 12);
    chk("t5_issue", k_iss - bi, 12);
    chk("t5_fd", fd_cnt - bf, 1);
    chk("t5_idle", 32'(busy), 0);

    // Reset mid-frame after pixel 5
    bp = k_pop;
    pulse_start();
    n = 0;
    while (k_pop - bp < 5 && n < 50) begin tick(); n++; end
    chk("t6_reach5", 32'(n < 50), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t6_valid", 32'(pix_valid), 0);
    chk("t6_fields", 32'({pixel_out, pix_row, pix_col, sof, eol, eof}), 0);
    chk("t6_rom", 32'({rom_en, rom_pix_row, rom_pix_col}), 0);
    chk("t6_busy_fd", 32'({busy, frame_done}), 0);
    bf = fd_cnt;
    tick();
    pulse_start();
    wait_valid(20, n);
    chk("t6_first", 32'({pixel_out, sof}), 32'h0001);
    wait_idle(100);
    chk("t6_count", k_pop, 12);
    chk("t6_fd", fd_cnt - bf, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
